result_packer: RTL and testbench
================================

RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 Parameter LEAD, default 2, meaning the number of leading skew bytes discarded per frame (range 0..7).
REQ-002 Parameter TRAIL, default 1, meaning the number of trailing skew bytes discarded per frame (range 0..7).
REQ-003 Parameter DEPTH, default 4, meaning the word FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 resetn  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  single-cycle frame-start pulse.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_in  input  8  skewed byte lane from the array alignment FIFO.
REQ-009 byte_ready  output  1  the block accepts byte_in in this cycle.
REQ-010 word_valid  output  1  word_data holds a valid word.
REQ-011 word_data  output  32  reassembled word; the first payload byte SHALL occupy bits [7:0].
REQ-012 word_ready  input  1  the consumer accepts word_data.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_err  output  1  sticky flag, set when a skew byte is nonzero.
REQ-015 fifo_count  output  $clog2(DEPTH)+1  number of words held in the FIFO.

Function
REQ-016 A byte SHALL be accepted in a cycle only when byte_valid and byte_ready are both high.
REQ-017 The state machine SHALL have four states: IDLE, SKIP, PACK, TRAIL.
REQ-018 In IDLE, byte_ready SHALL be 0.
REQ-019 In IDLE, start SHALL move to SKIP, or to PACK if LEAD=0; the same edge SHALL clear frame_err and the byte counter.
REQ-020 A start pulse received outside IDLE SHALL be ignored.
REQ-021 In SKIP, byte_ready SHALL be 1; each accepted byte SHALL be discarded and SHALL increment the counter; after LEAD bytes the state SHALL move to PACK.
REQ-022 In PACK, byte_ready SHALL be 1 for lanes 0-2 and SHALL be ~fifo_full for lane 3.
REQ-023 In PACK, accepted bytes SHALL fill lanes 0..3 in order.
REQ-024 On acceptance of the lane-3 byte, the assembled word SHALL be pushed into the FIFO on the same edge.
REQ-025 After the push, the state SHALL move to TRAIL, or to IDLE if TRAIL=0.
REQ-026 In TRAIL, byte_ready SHALL be 1; after TRAIL accepted bytes are discarded, the state SHALL move to IDLE.
REQ-027 Any accepted SKIP or TRAIL byte not equal to 0x00 SHALL set frame_err on the next edge; frame_err SHALL hold until the next accepted start or reset.
REQ-028 Gaps in byte_valid SHALL stall the state machine without changing its state or the counter.
REQ-029 word_valid SHALL equal ~fifo_empty.
REQ-030 word_data SHALL be the FIFO head word, driven from registered storage.
REQ-031 A pop SHALL occur when word_valid and word_ready are both high.
REQ-032 Latency: word_valid SHALL rise in the cycle after the edge that accepts the lane-3 byte, when the FIFO was empty.
REQ-033 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-034 A push into a full FIFO SHALL be impossible by construction (REQ-022).
REQ-035 word_ready asserted while the FIFO is empty SHALL have no effect.
REQ-036 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from a count or an extra pointer bit.

Reset
REQ-037 While resetn is low, the block SHALL enter IDLE and clear the FIFO pointers, the count and the lane registers.
REQ-038 Reset values: byte_ready=0, word_valid=0, word_data=0, busy=0, frame_err=0, fifo_count=0.
REQ-039 Reset asserted mid-frame SHALL discard the partial word and any stored words; the first post-reset frame SHALL require a new start.

Structure
REQ-040 The state encoding and the default LEAD, TRAIL and DEPTH constants SHALL reside in the shared array package used by the alignment blocks.
REQ-041 The word FIFO SHALL be a sub-module named result_word_fifo (parameters WIDTH=32 and DEPTH), instantiated once.

Verification
REQ-042 start; bytes 00 00 EF BE AD DE 00 with word_ready=1 -> one word 0xDEADBEEF, word_valid high for 1 cycle, frame_err=0, busy low after the 7th byte.
REQ-043 start; bytes 00 5A 11 22 33 44 00 -> word 0x44332211, frame_err=1 until the next start; the next clean frame clears it.
REQ-044 word_ready=0; 5 clean frames -> fifo_count=4; in frame 5, byte_ready=0 at lane 3 until one word is popped, then the 5th word is accepted; FIFO order is preserved.
REQ-045 byte_valid toggled every other cycle across a frame, plus start pulses issued mid-frame -> the same single correct word; the mid-frame starts are ignored.
REQ-046 resetn pulsed low after lane 1 with 2 words stored -> all outputs at reset values; the next full frame yields the correct word only.
REQ-047 Simultaneous push and pop with fifo_count=2 -> fifo_count remains 2 and the popped word is the oldest.

Source files
------------

// File: rtl/result_packer_pkg.sv
// Shared definitions for the array alignment / result packing path:
// packer state encoding, default skew and FIFO sizing, skew-byte check.
package result_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_PACK  = 2'd2,
    ST_TRAIL = 2'd3
  } pack_state_e;

  localparam int DEFAULT_LEAD  = 2;
  localparam int DEFAULT_TRAIL = 1;
  localparam int DEFAULT_DEPTH = 4;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  // Skew padding is expected to be all zeros; anything else marks a bad frame.
  function automatic logic is_skew_err(input logic [BYTE_W-1:0] b);
    return (b != '0);
  endfunction

endpackage

// File: rtl/result_word_fifo.sv
// Word FIFO between the packer and the result consumer. The head word is
// read straight from registered storage; full/empty come from the count.
module result_word_fifo
  import result_packer_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/result_packer.sv
// Strips leading/trailing skew bytes from each frame and packs four payload
// bytes (first byte in [7:0]) into a word queued in result_word_fifo.
module result_packer
  import result_packer_pkg::*;
#(
  parameter int LEAD  = DEFAULT_LEAD,
  parameter int TRAIL = DEFAULT_TRAIL,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  output logic                   byte_ready,
  output logic                   word_valid,
  output logic [31:0]            word_data,
  input  logic                   word_ready,
  output logic                   busy,
  output logic                   frame_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  // Counter terminal values; unused when the matching skew length is zero.
  localparam logic [2:0] LEAD_LAST  = 3'(LEAD - 1);
  localparam logic [2:0] TRAIL_LAST = 3'(TRAIL - 1);

  pack_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0][7:0] lanes_q, lanes_d;
  logic            frame_err_q, frame_err_d;
  logic            accept, push, fifo_full, fifo_empty;
  logic [31:0]     push_data;

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      ST_SKIP:  byte_ready = 1'b1;
      ST_PACK:  byte_ready = (lane_q == 2'd3) ? ~fifo_full : 1'b1;
      ST_TRAIL: byte_ready = 1'b1;
      default:  byte_ready = 1'b0;
    endcase
  end

  assign accept    = byte_valid & byte_ready;
  assign push_data = {byte_in, lanes_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    lanes_d     = lanes_q;
    frame_err_d = frame_err_q;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d       = '0;
          lane_d      = '0;
          frame_err_d = 1'b0;
          state_d     = (LEAD == 0) ? ST_PACK : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (accept) begin
          if (is_skew_err(byte_in)) frame_err_d = 1'b1;
          if (cnt_q == LEAD_LAST) begin
            cnt_d   = '0;
            state_d = ST_PACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PACK: begin
        if (accept) begin
          if (lane_q == 2'd3) begin
            push    = 1'b1;
            lane_d  = '0;
            cnt_d   = '0;
            state_d = (TRAIL == 0) ? ST_IDLE : ST_TRAIL;
          end else begin
            lanes_d[lane_q] = byte_in;
            lane_d          = lane_q + 1'b1;
          end
        end
      end
      ST_TRAIL: begin
        if (accept) begin
          if (is_skew_err(byte_in)) frame_err_d = 1'b1;
          if (cnt_q == TRAIL_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      lanes_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      lanes_q     <= lanes_d;
      frame_err_q <= frame_err_d;
    end
  end

  result_word_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (word_ready),
    .rd_data   (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign word_valid = ~fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer with default LEAD=2, TRAIL=1, DEPTH=4.
module tb_result_packer;

  logic        clk = 1'b0;
  logic        resetn, start, byte_valid, word_ready;
  logic [7:0]  byte_in;
  logic        byte_ready, word_valid, busy, frame_err;
  logic [31:0] word_data;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_packer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .fifo_count (fifo_count)
  );

  // All stimulus tasks begin and end just after a falling edge.
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout: byte_ready=%0b required 1", byte_ready);
    end
    @(posedge clk); @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] t0);
    start_pulse();
    send_byte(s0);
    send_byte(s1);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    send_byte(t0);
  endtask

  task automatic pop_word();
    word_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_byte_ready: got %0b required 0", byte_ready); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_word_valid: got %0b required 0", word_valid); end
    checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL rst_word_data: got %h required 00000000", word_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %0b required 0", frame_err); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d required 0", fifo_count); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL idle_byte_ready: got %0b required 0", byte_ready); end
  endtask

  task automatic test_basic();
    word_ready = 1'b1;
    start_pulse();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b required 1", busy); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_skip_ready: got %0b required 1", byte_ready); end
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_word_valid: got %0b required 1", word_valid); end
    checks++; if (word_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_word_data: got %h required deadbeef", word_data); end
    send_byte(8'h00);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle: got %0b required 0", word_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b required 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %0b required 0", frame_err); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL basic_count: got %0d required 0", fifo_count); end
    word_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    start_pulse();
    send_byte(8'h00);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clean_skip: got %0b required 0", frame_err); end
    send_byte(8'h5A);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %0b required 1", frame_err); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h00);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %0b required 1", frame_err); end
    checks++; if (word_data !== 32'h44332211) begin errors++; $display("FAIL ferr_word: got %h required 44332211", word_data); end
    pop_word();
    start_pulse();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear_on_start: got %0b required 0", frame_err); end
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clean_frame: got %0b required 0", frame_err); end
    checks++; if (word_data !== 32'h04030201) begin errors++; $display("FAIL ferr_clean_word: got %h required 04030201", word_data); end
    pop_word();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = {8'hA0 + 8'(k), 8'hB0 + 8'(k), 8'hC0 + 8'(k), 8'hD0 + 8'(k)};
    for (int k = 0; k < 4; k++) send_frame(w[k], 8'h00, 8'h00, 8'h00);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d required 4", fifo_count); end
    start_pulse();
    send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_byte(w[4][8*i +: 8]);
    byte_valid = 1'b1;
    byte_in    = w[4][31:24];
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL bp_lane3_stall: got %0b required 0", byte_ready); end
    repeat (2) @(negedge clk);
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL bp_lane3_hold: got %0b required 0", byte_ready); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_hold: got %0d required 4", fifo_count); end
    checks++; if (word_data !== w[0]) begin errors++; $display("FAIL bp_head0: got %h required %h", word_data, w[0]); end
    word_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    word_ready = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL bp_count_after_pop: got %0d required 3", fifo_count); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL bp_lane3_release: got %0b required 1", byte_ready); end
    @(posedge clk); @(negedge clk);
    byte_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_refill: got %0d required 4", fifo_count); end
    send_byte(8'h00);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %0b required 0", busy); end
    for (int k = 1; k < 5; k++) begin
      checks++; if (word_data !== w[k]) begin errors++; $display("FAIL bp_order%0d: got %h required %h", k, word_data, w[k]); end
      pop_word();
    end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b required 0", word_valid); end
  endtask

  task automatic test_gaps();
    logic [7:0] seq [7];
    seq = '{8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    start_pulse();
    for (int i = 0; i < 7; i++) begin
      byte_valid = 1'b0;
      start      = (i == 0 || i == 2 || i == 4);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy%0d: got %0b required 1", i, busy); end
      send_byte(seq[i]);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end: got %0b required 0", busy); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL gap_count: got %0d required 1", fifo_count); end
    checks++; if (word_data !== 32'h12345678) begin errors++; $display("FAIL gap_word: got %h required 12345678", word_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL gap_frame_err: got %0b required 0", frame_err); end
    pop_word();
  endtask

  task automatic test_mid_reset();
    send_frame(32'hCAFEF00D, 8'h00, 8'h00, 8'h00);
    send_frame(32'h0BADC0DE, 8'h00, 8'h7E, 8'h00);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mr_count_pre: got %0d required 2", fifo_count); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL mr_ferr_pre: got %0b required 1", frame_err); end
    start_pulse();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    resetn = 1'b0;
    #1;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL mr_byte_ready: got %0b required 0", byte_ready); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL mr_word_valid: got %0b required 0", word_valid); end
    checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL mr_word_data: got %h required 00000000", word_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %0b required 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mr_frame_err: got %0b required 0", frame_err); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mr_fifo_count: got %0d required 0", fifo_count); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL mr_needs_start: got %0b required 0", byte_ready); end
    @(negedge clk);
    byte_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_stay_idle: got %0b required 0", busy); end
    send_frame(32'h89ABCDEF, 8'h00, 8'h00, 8'h00);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mr_count_post: got %0d required 1", fifo_count); end
    checks++; if (word_data !== 32'h89ABCDEF) begin errors++; $display("FAIL mr_word_post: got %h required 89abcdef", word_data); end
    pop_word();
  endtask

  task automatic test_push_pop();
    logic [31:0] c;
    c = 32'h55667788;
    send_frame(32'h11112222, 8'h00, 8'h00, 8'h00);
    send_frame(32'h33334444, 8'h00, 8'h00, 8'h00);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_count_pre: got %0d required 2", fifo_count); end
    start_pulse();
    send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_byte(c[8*i +: 8]);
    byte_valid = 1'b1;
    byte_in    = c[31:24];
    word_ready = 1'b1;
    checks++; if (word_data !== 32'h11112222) begin errors++; $display("FAIL pp_pop_oldest: got %h required 11112222", word_data); end
    @(posedge clk); @(negedge clk);
    byte_valid = 1'b0;
    word_ready = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_count_same: got %0d required 2", fifo_count); end
    checks++; if (word_data !== 32'h33334444) begin errors++; $display("FAIL pp_next_head: got %h required 33334444", word_data); end
    send_byte(8'h00);
    pop_word();
    checks++; if (word_data !== c) begin errors++; $display("FAIL pp_last: got %h required %h", word_data, c); end
    pop_word();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d required 0", fifo_count); end
    pop_word();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pp_pop_empty: got %0d required 0", fifo_count); end
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    word_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_err();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
